// File: rtl/dmi_tl_arbiter_pkg.sv
// Shared types and constants for the DMI-to-TL-UL arbiter.
// The DRAIN state exists only when DMI_ARB_TIMEOUT_EN is defined.
package dmi_tl_pkg;

`ifdef DMI_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_WAIT_D,
        ST_RESP,
        ST_DRAIN
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_WAIT_D,
        ST_RESP
    } state_e;
`endif

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [2:0] TL_GET     = 3'd4;
    localparam logic [2:0] TL_PUTFULL = 3'd0;

    localparam logic [8:0] NOP_ADDR = 9'h048;

    localparam logic [1:0] RESP_OK      = 2'd0;
    localparam logic [1:0] RESP_FAILED  = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    function automatic logic [2:0] tlOpcode(input logic [1:0] op);
        return (op == OP_READ) ? TL_GET : TL_PUTFULL;
    endfunction

    // Opcodes 0 and 3 are both treated as a harmless write of zero to NOP_ADDR.
    function automatic logic [8:0] tlAddress(input logic [1:0] op, input logic [6:0] addr);
        return (op == OP_READ || op == OP_WRITE) ? {addr, 2'b00} : NOP_ADDR;
    endfunction

    function automatic logic [31:0] tlData(input logic [1:0] op, input logic [31:0] data);
        return (op == OP_WRITE) ? data : 32'h0;
    endfunction

endpackage

// File: rtl/dmi_tl_arbiter_if.sv
// Bundle of the two DMI requester ports and the TL-UL A/D channels.
// The master modport is the arbiter's view; slave is the environment's view.
interface dmi_tl_arbiter_if;
    logic        r0_req_valid;
    logic        r0_req_ready;
    logic [6:0]  r0_req_addr;
    logic [1:0]  r0_req_op;
    logic [31:0] r0_req_data;
    logic        r0_resp_valid;
    logic        r0_resp_ready;
    logic [31:0] r0_resp_data;
    logic [1:0]  r0_resp_resp;

    logic        r1_req_valid;
    logic        r1_req_ready;
    logic [6:0]  r1_req_addr;
    logic [1:0]  r1_req_op;
    logic [31:0] r1_req_data;
    logic        r1_resp_valid;
    logic        r1_resp_ready;
    logic [31:0] r1_resp_data;
    logic [1:0]  r1_resp_resp;

    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [8:0]  a_address;
    logic [31:0] a_data;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_data;
    logic        d_denied;
    logic        d_corrupt;

    modport master (
        input  r0_req_valid, r0_req_addr, r0_req_op, r0_req_data, r0_resp_ready,
        input  r1_req_valid, r1_req_addr, r1_req_op, r1_req_data, r1_resp_ready,
        input  a_ready, d_valid, d_data, d_denied, d_corrupt,
        output r0_req_ready, r0_resp_valid, r0_resp_data, r0_resp_resp,
        output r1_req_ready, r1_resp_valid, r1_resp_data, r1_resp_resp,
        output a_valid, a_opcode, a_address, a_data, d_ready
    );

    modport slave (
        output r0_req_valid, r0_req_addr, r0_req_op, r0_req_data, r0_resp_ready,
        output r1_req_valid, r1_req_addr, r1_req_op, r1_req_data, r1_resp_ready,
        output a_ready, d_valid, d_data, d_denied, d_corrupt,
        input  r0_req_ready, r0_resp_valid, r0_resp_data, r0_resp_resp,
        input  r1_req_ready, r1_resp_valid, r1_resp_data, r1_resp_resp,
        input  a_valid, a_opcode, a_address, a_data, d_ready
    );
endinterface

// File: rtl/dmi_tl_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie.
module dmi_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);
    logic prefer1_q;

    assign gnt_idx_o = req_i[1] & (~req_i[0] | prefer1_q);
    assign gnt_o     = {req_i[1] & gnt_idx_o, req_i[0] & ~gnt_idx_o};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prefer1_q <= 1'b0;
        end else if (accept_i) begin
            prefer1_q <= ~gnt_idx_o;
        end
    end
endmodule

// File: rtl/dmi_tl_arbiter.sv
// Arbitrates two DMI requesters onto one TL-UL port, one transaction at a time.
// Optional D-channel timeout with drain state: define DMI_ARB_TIMEOUT_EN.
module dmi_tl_arbiter
    import dmi_tl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clock,
    input logic              reset_n,
    dmi_tl_arbiter_if.master bus
);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        grant_q;
    logic        a_valid_q;
    logic [2:0]  a_opcode_q;
    logic [8:0]  a_address_q;
    logic [31:0] a_data_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [1:0]  resp_resp_q;

    logic [1:0]  reqVec;
    logic [1:0]  gnt;
    logic        gntIdx;
    logic        inIdle;
    logic        accept;
    logic        respReady;
    logic [1:0]  selOp;
    logic [6:0]  selAddr;
    logic [31:0] selData;

    assign reqVec = {bus.r1_req_valid, bus.r0_req_valid};
    assign inIdle = (state_q == ST_IDLE);

    dmi_rr_arb2 u_arb (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .req_i     (reqVec),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gntIdx)
    );

    // Ready is combinational so a new grant can be taken in the first IDLE cycle.
    assign bus.r0_req_ready = reset_n & inIdle & gnt[0];
    assign bus.r1_req_ready = reset_n & inIdle & gnt[1];
    assign accept = (bus.r0_req_valid & bus.r0_req_ready) |
                    (bus.r1_req_valid & bus.r1_req_ready);

    assign selOp   = gntIdx ? bus.r1_req_op   : bus.r0_req_op;
    assign selAddr = gntIdx ? bus.r1_req_addr : bus.r0_req_addr;
    assign selData = gntIdx ? bus.r1_req_data : bus.r0_req_data;

    assign respReady = grant_q ? bus.r1_resp_ready : bus.r0_resp_ready;

    assign bus.a_valid   = a_valid_q;
    assign bus.a_opcode  = a_opcode_q;
    assign bus.a_address = a_address_q;
    assign bus.a_data    = a_data_q;

    assign bus.r0_resp_valid = resp_valid_q & ~grant_q;
    assign bus.r1_resp_valid = resp_valid_q & grant_q;
    assign bus.r0_resp_data  = resp_data_q;
    assign bus.r1_resp_data  = resp_data_q;
    assign bus.r0_resp_resp  = resp_resp_q;
    assign bus.r1_resp_resp  = resp_resp_q;

`ifdef DMI_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    assign bus.d_ready = (state_q == ST_WAIT_D) || (state_q == ST_DRAIN);
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutLast;
    assign bus.d_ready = (state_q == ST_WAIT_D);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            a_valid_q    <= 1'b0;
            a_opcode_q   <= 3'd0;
            a_address_q  <= 9'd0;
            a_data_q     <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_resp_q  <= RESP_OK;
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q     <= gntIdx;
                        a_opcode_q  <= tlOpcode(selOp);
                        a_address_q <= tlAddress(selOp, selAddr);
                        a_data_q    <= tlData(selOp, selData);
                        a_valid_q   <= 1'b1;
                        state_q     <= ST_SEND_A;
`ifdef DMI_ARB_TIMEOUT_EN
                        cnt_q       <= 8'd0;
`endif
                    end
                end
                ST_SEND_A: begin
                    if (bus.a_ready) begin
                        a_valid_q <= 1'b0;
                        state_q   <= ST_WAIT_D;
                    end
                end
                ST_WAIT_D: begin
                    if (bus.d_valid) begin
                        resp_data_q  <= (a_opcode_q == TL_GET) ? bus.d_data : 32'd0;
                        resp_resp_q  <= (bus.d_denied | bus.d_corrupt) ? RESP_FAILED : RESP_OK;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
`ifdef DMI_ARB_TIMEOUT_EN
                    end else if (cnt_q == TimeoutLast) begin
                        resp_data_q  <= 32'd0;
                        resp_resp_q  <= RESP_TIMEOUT;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                ST_RESP: begin
                    if (respReady) begin
                        resp_valid_q <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
                        // A timed-out beat may still arrive; swallow it before new work.
                        state_q <= (resp_resp_q == RESP_TIMEOUT) ? ST_DRAIN : ST_IDLE;
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end
`ifdef DMI_ARB_TIMEOUT_EN
                ST_DRAIN: begin
                    if (bus.d_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_tl_arbiter.sv
// Directed and randomized bench for dmi_tl_arbiter with a transaction-level model.
// The timeout/drain section runs only when DMI_ARB_TIMEOUT_EN is defined.
module tb_dmi_tl_arbiter;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    int lastGrant = 1;

    dmi_tl_arbiter_if bus();

    dmi_tl_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [1:0] op0, input logic [6:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [1:0] op1, input logic [6:0] a1, input logic [31:0] d1);
        bus.r0_req_valid = v0;
        bus.r0_req_op    = op0;
        bus.r0_req_addr  = a0;
        bus.r0_req_data  = d0;
        bus.r1_req_valid = v1;
        bus.r1_req_op    = op1;
        bus.r1_req_addr  = a1;
        bus.r1_req_data  = d1;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 2'd0, 7'd0, 32'd0, 1'b0, 2'd0, 7'd0, 32'd0);
        bus.r0_resp_ready = 1'b0;
        bus.r1_resp_ready = 1'b0;
        bus.a_ready       = 1'b0;
        bus.d_valid       = 1'b0;
        bus.d_data        = 32'd0;
        bus.d_denied      = 1'b0;
        bus.d_corrupt     = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_r0_req_ready"}, bus.r0_req_ready, 0);
        checkOutput({tag, "_r1_req_ready"}, bus.r1_req_ready, 0);
        checkOutput({tag, "_a_valid"}, bus.a_valid, 0);
        checkOutput({tag, "_d_ready"}, bus.d_ready, 0);
        checkOutput({tag, "_resp_valid"}, {bus.r0_resp_valid, bus.r1_resp_valid}, 0);
        checkOutput({tag, "_a_fields"}, {bus.a_opcode, bus.a_address, bus.a_data}, 0);
        checkOutput({tag, "_resp_data"}, {bus.r0_resp_data, bus.r1_resp_data}, 0);
        checkOutput({tag, "_resp_resp"}, {bus.r0_resp_resp, bus.r1_resp_resp}, 0);
    endtask

    // Expected A-channel beat {opcode, address, data} for a DMI request.
    function automatic logic [43:0] expA(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        case (op)
            2'd1:    return {3'd4, addr, 2'b00, 32'h0};
            2'd2:    return {3'd0, addr, 2'b00, data};
            default: return {3'd0, 9'h048, 32'h0};
        endcase
    endfunction

    // Called at a falling edge; returns at a falling edge with the DUT back in IDLE.
    task automatic doTxn(input logic v0, input logic [1:0] op0, input logic [6:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [1:0] op1, input logic [6:0] a1, input logic [31:0] d1,
                         input int aStall, input int dDelay, input logic [31:0] dData,
                         input logic denied, input logic corrupt);
        int winner;
        int n;
        logic [1:0]  wOp;
        logic [43:0] ea;
        logic [31:0] expData;
        logic [1:0]  expResp;
        applyStimulus(v0, op0, a0, d0, v1, op1, a1, d1);
        winner = (v0 && v1) ? ((lastGrant == 0) ? 1 : 0) : (v1 ? 1 : 0);
        n = 0;
        #1;
        while (!(bus.r0_req_ready || bus.r1_req_ready) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput("req_ready_seen", n < 20, 1);
        checkOutput("grant_r0", bus.r0_req_ready, winner == 0);
        checkOutput("grant_r1", bus.r1_req_ready, winner == 1);
        lastGrant = winner;
        wOp = (winner == 1) ? op1 : op0;
        ea  = (winner == 1) ? expA(op1, a1, d1) : expA(op0, a0, d0);
        @(negedge clock);
        if (winner == 1) bus.r1_req_valid = 1'b0;
        else             bus.r0_req_valid = 1'b0;
        checkOutput("a_valid_next", bus.a_valid, 1);
        checkOutput("busy_no_ready", {bus.r0_req_ready, bus.r1_req_ready}, 0);
        for (int i = 0; i < aStall; i++) begin
            checkOutput("a_stall_fields", {bus.a_valid, bus.a_opcode, bus.a_address, bus.a_data}, {1'b1, ea});
            @(negedge clock);
        end
        checkOutput("a_fields", {bus.a_opcode, bus.a_address, bus.a_data}, ea);
        bus.a_ready = 1'b1;
        @(negedge clock);
        bus.a_ready = 1'b0;
        checkOutput("a_valid_drop", bus.a_valid, 0);
        checkOutput("d_ready_wait", bus.d_ready, 1);
        repeat (dDelay) @(negedge clock);
        bus.d_valid   = 1'b1;
        bus.d_data    = dData;
        bus.d_denied  = denied;
        bus.d_corrupt = corrupt;
        @(negedge clock);
        bus.d_valid   = 1'b0;
        bus.d_denied  = 1'b0;
        bus.d_corrupt = 1'b0;
        bus.d_data    = $urandom;
        expData = (wOp == 2'd1) ? dData : 32'h0;
        expResp = (denied || corrupt) ? 2'd2 : 2'd0;
        checkOutput("d_ready_after", bus.d_ready, 0);
        checkOutput("resp_valid_r0", bus.r0_resp_valid, winner == 0);
        checkOutput("resp_valid_r1", bus.r1_resp_valid, winner == 1);
        checkOutput("resp_data", (winner == 1) ? bus.r1_resp_data : bus.r0_resp_data, expData);
        checkOutput("resp_resp", (winner == 1) ? bus.r1_resp_resp : bus.r0_resp_resp, expResp);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        if (winner == 1) bus.r1_resp_ready = 1'b1;
        else             bus.r0_resp_ready = 1'b1;
        @(negedge clock);
        bus.r0_resp_ready = 1'b0;
        bus.r1_resp_ready = 1'b0;
        checkOutput("resp_valid_clear", {bus.r0_resp_valid, bus.r1_resp_valid}, 0);
    endtask

    initial begin
        int n;
        logic v0;
        logic v1;
        clearInputs();
        bus.r0_req_valid = 1'b1;
        reset_n = 1'b0;
        #12;
        checkQuiet("reset");
        @(negedge clock);
        bus.r0_req_valid = 1'b0;
        reset_n = 1'b1;
        lastGrant = 1;
        @(negedge clock);

        $display("[TB] directed read, denied write, nop with A stall, corrupt read");
        doTxn(1'b1, 2'd1, 7'h11, $urandom, 1'b0, 2'd0, 7'd0, 32'd0, 0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
        doTxn(1'b0, 2'd0, 7'd0, 32'd0, 1'b1, 2'd2, 7'h10, 32'h1, 1, 1, $urandom, 1'b1, 1'b0);
        doTxn(1'b1, 2'd0, 7'($urandom), $urandom, 1'b0, 2'd0, 7'd0, 32'd0, 5, 0, $urandom, 1'b0, 1'b0);
        doTxn(1'b1, 2'd1, 7'($urandom), $urandom, 1'b0, 2'd0, 7'd0, 32'd0, 0, 3, 32'hA5A5_0F0F, 1'b0, 1'b1);
        doTxn(1'b0, 2'd0, 7'd0, 32'd0, 1'b1, 2'd3, 7'($urandom), $urandom, 2, 0, $urandom, 1'b0, 1'b0);

        $display("[TB] back-to-back contention after reset");
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        lastGrant = 1;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            doTxn(1'b1, 2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                  1'b1, 2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0, 1'b0);
        end
        clearInputs();

        $display("[TB] randomized transactions");
        for (int k = 0; k < 10; k++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            doTxn(v0, 2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                  v1, 2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end
        clearInputs();
        @(negedge clock);

        $display("[TB] reset in WAIT_D");
        applyStimulus(1'b1, 2'd1, 7'h22, 32'd0, 1'b0, 2'd0, 7'd0, 32'd0);
        @(negedge clock);
        bus.r0_req_valid = 1'b0;
        bus.a_ready = 1'b1;
        @(negedge clock);
        bus.a_ready = 1'b0;
        checkOutput("rst_pre_d_ready", bus.d_ready, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkQuiet("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        lastGrant = 1;
        bus.d_valid = 1'b1;
        bus.d_data  = 32'h1234_5678;
        @(negedge clock);
        bus.d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("stray_d_no_resp", {bus.r0_resp_valid, bus.r1_resp_valid, bus.a_valid, bus.d_ready}, 0);
            @(negedge clock);
        end

`ifdef DMI_ARB_TIMEOUT_EN
        $display("[TB] D-channel timeout and drain");
        applyStimulus(1'b1, 2'd1, 7'h05, 32'd0, 1'b0, 2'd0, 7'd0, 32'd0);
        #1;
        checkOutput("to_grant", bus.r0_req_ready, 1);
        @(negedge clock);
        bus.r0_req_valid = 1'b0;
        lastGrant = 0;
        bus.a_ready = 1'b1;
        @(negedge clock);
        bus.a_ready = 1'b0;
        n = 0;
        while (!bus.r0_resp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("to_cycles", n, TO);
        checkOutput("to_resp", bus.r0_resp_resp, 3);
        checkOutput("to_data", bus.r0_resp_data, 0);
        bus.r0_resp_ready = 1'b1;
        @(negedge clock);
        bus.r0_resp_ready = 1'b0;
        checkOutput("drain_d_ready", bus.d_ready, 1);
        bus.r1_req_valid = 1'b1;
        #1;
        checkOutput("drain_blocks_req", bus.r1_req_ready, 0);
        bus.r1_req_valid = 1'b0;
        bus.d_valid = 1'b1;
        @(negedge clock);
        bus.d_valid = 1'b0;
        checkOutput("drain_done", {bus.d_ready, bus.r0_resp_valid, bus.r1_resp_valid}, 0);
        doTxn(1'b0, 2'd0, 7'd0, 32'd0, 1'b1, 2'd1, 7'h33, 32'd0, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        clearInputs();
`else
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmi_tl_arbiter.md
DMI_TL_ARBITER -- requirements
Module: dmi_tl_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the D-channel wait limit in cycles (range 1..255); it is used only when DMI_ARB_TIMEOUT_EN is defined.
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 rN_req_valid / rN_req_ready  in/out  1  DMI request handshake for requester N (N=0,1).
REQ-005 rN_req_addr  in  7  DMI word address.
REQ-006 rN_req_op  in  2  operation: 1 read, 2 write, 0/3 nop.
REQ-007 rN_req_data  in  32  write data.
REQ-008 rN_resp_valid / rN_resp_ready  out/in  1  DMI response handshake.
REQ-009 rN_resp_data  out  32  read data; 0 for writes and nops.
REQ-010 rN_resp_resp  out  2  status: 0 ok, 2 failed, 3 timeout.
REQ-011 a_valid / a_ready  out/in  1  TL-UL A-channel handshake.
REQ-012 a_opcode / a_address / a_data  out  3/9/32  A-channel fields.
REQ-013 d_valid / d_ready  in/out  1  D-channel handshake.
REQ-014 d_data / d_denied / d_corrupt  in  32/1/1  D-channel fields.

Function
REQ-015 FSM states: IDLE, SEND_A, WAIT_D, RESP, plus DRAIN when the feature is enabled; only one transaction is outstanding at any time.
REQ-016 In IDLE, rN_req_ready is asserted combinationally only for the arbitration winner; every other requester sees ready 0.
REQ-017 Arbitration is round-robin: a single requester wins alone; with both valid, the requester not granted last wins; after reset r0 wins the first tie.
REQ-018 The request handshake captures addr/op/data/grant into registers and moves IDLE->SEND_A; the earliest a_valid is the next cycle.
REQ-019 Field mapping: op=1 -> opcode 4, address {addr,2'b00}, data 0; op=2 -> opcode 0, address {addr,2'b00}, data=req_data; op=0/3 -> opcode 0, address 9'h048, data 0.
REQ-020 In SEND_A, a_valid is held high with stable fields until a_ready; then the FSM moves to WAIT_D.
REQ-021 In WAIT_D, d_ready=1; on d_valid the FSM captures resp_data (d_data for reads, else 0) and resp_resp (2 if d_denied|d_corrupt, else 0), then moves to RESP.
REQ-022 In RESP, only the granted rN_resp_valid is high until rN_resp_ready; then the FSM returns to IDLE, and a new grant is possible that same IDLE cycle.
REQ-023 d_valid outside WAIT_D/DRAIN is ignored; d_ready is 0 there.
REQ-024 Request valid deasserting before ready has no effect on state.

Reset
REQ-025 Under reset_n=0: FSM=IDLE, RR pointer=r0, all valids/readies 0, a_opcode/a_address/a_data 0, resp_data 0, resp_resp 0, timeout counter 0.
REQ-026 Reset assertion mid-transaction aborts it immediately; a D beat arriving after release is ignored per REQ-023.

Configuration
REQ-027 With DMI_ARB_TIMEOUT_EN defined, an 8-bit counter runs in WAIT_D.
REQ-028 When the counter reaches TIMEOUT_CYCLES with no d_valid, the FSM enters RESP with resp_resp=3 and resp_data=0.
REQ-029 After that timeout response completes, the FSM enters DRAIN (d_ready=1, requests blocked) and returns to IDLE on the next d_valid.
REQ-030 Without DMI_ARB_TIMEOUT_EN, WAIT_D waits indefinitely, and neither the counter nor DRAIN exists.

Structure
REQ-031 Package dmi_tl_pkg holds the FSM state enum, the op codes (NOP/READ/WRITE), the TL opcodes (GET=4, PUTFULL=0), NOP_ADDR=9'h048 and the resp codes.
REQ-032 Sub-module dmi_rr_arb2 holds the two-way round-robin grant and pointer; all other logic is flat.

Verification
REQ-033 r0 read addr 7'h11 -> A: opcode 4, address 9'h044; D d_data=32'hDEADBEEF -> r0_resp_data=32'hDEADBEEF, resp 0.
REQ-034 r1 write addr 7'h10, data 32'h1 -> A: opcode 0, address 9'h040, data 32'h1; D d_denied=1 -> r1_resp_resp=2.
REQ-035 r0 and r1 valid continuously for 4 transactions -> grants r0,r1,r0,r1; r1 never sees resp_valid for r0's transaction.
REQ-036 r0 op=0 -> A: opcode 0, address 9'h048, data 0; with a_ready held low 5 cycles, fields stay stable until a_ready.
REQ-037 Feature on, TIMEOUT_CYCLES=8, D withheld -> resp_resp=3 after 8 WAIT_D cycles; a late d_valid is drained; the next request proceeds normally.
REQ-038 reset_n pulsed low in WAIT_D -> all outputs 0 asynchronously; a subsequent stray d_valid produces no response.
